player_ctl: RTL and testbench

Per-frame motion controller for the player sprite. It reads the debounced control buttons and, once per frame during vertical blanking, updates the sprite position (`x_value`, `y_value`) that feeds the rectangle/sprite draw stage. Positions are therefore stable for the whole active video period. It implements the jump state machine: ground walk, jump charge, airborne flight with gravity, wall bounce, ceiling clamp and landing.

---
 rtl/player_ctl_if.sv | 23 ++
 rtl/player_ctl.sv | 169 ++++++++++++++++
 tb/tb_player_ctl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/player_ctl_if.sv
// Button/blanking inputs and sprite outputs of the player motion controller.
// The controller is the slave; the video timing/button side is the master.
interface player_ctl_if;
    logic        vblnk;
    logic        btn_left;
    logic        btn_right;
    logic        btn_jump;
    logic [11:0] x_value;
    logic [11:0] y_value;
    logic [1:0]  pose;
    logic        facing;
    logic        landed;

    modport master (
        output vblnk, btn_left, btn_right, btn_jump,
        input  x_value, y_value, pose, facing, landed
    );

    modport slave (
        input  vblnk, btn_left, btn_right, btn_jump,
        output x_value, y_value, pose, facing, landed
    );
endinterface

// File: rtl/player_ctl.sv
// Per-frame player sprite motion: ground walk, jump charge, airborne flight with
// gravity, wall bounce, ceiling clamp and landing, updated once per vblnk rising edge.
module player_ctl #(
    parameter int SCREEN_W   = 800,
    parameter int SCREEN_H   = 600,
    parameter int REC_W      = 48,
    parameter int REC_H      = 64,
    parameter int X_START    = 376,
    parameter int WALK_SPEED = 2,
    parameter int AIR_SPEED  = 3,
    parameter int GRAVITY    = 1,
    parameter int VY_MAX     = 12,
    parameter int JUMP_BASE  = 4,
    parameter int CHARGE_MAX = 30
) (
    input logic         clk,
    input logic         rst_n,
    player_ctl_if.slave bus
);

    localparam logic signed [12:0] GROUND_Y = 13'(SCREEN_H - REC_H);
    localparam logic signed [12:0] X_MAX    = 13'(SCREEN_W - REC_W);
    localparam logic signed [12:0] X_INIT   = 13'(X_START);
    localparam logic signed [12:0] WALK_S   = 13'(WALK_SPEED);
    localparam logic signed [7:0]  AIR_S    = 8'(AIR_SPEED);
    localparam logic signed [7:0]  GRAV_S   = 8'(GRAVITY);
    localparam logic signed [7:0]  VYMAX_S  = 8'(VY_MAX);
    localparam logic signed [7:0]  JBASE_S  = 8'(JUMP_BASE);
    localparam logic [4:0]         CHG_MAX  = 5'(CHARGE_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WALK   = 2'd1,
        S_CHARGE = 2'd2,
        S_AIR    = 2'd3
    } state_t;

    state_t             state_q;
    logic               vblnk_q;
    logic               tick_q;
    logic signed [12:0] x_q;
    logic signed [12:0] y_q;
    logic signed [7:0]  vx_q;
    logic signed [7:0]  vy_q;
    logic [4:0]         charge_q;
    logic               facing_q;
    logic               landed_q;

    logic signed [12:0] x_air_d;
    logic signed [12:0] y_air_d;
    logic signed [12:0] x_left_d;
    logic signed [12:0] x_right_d;
    logic signed [7:0]  vy_grav_d;
    logic signed [7:0]  vy_launch_d;
    logic signed [7:0]  vx_launch_d;
    logic [4:0]         charge_inc_d;
    logic [4:0]         charge_fin_d;
    logic               launch_d;
    logic               left_only;
    logic               right_only;

    assign left_only  = bus.btn_left & ~bus.btn_right;
    assign right_only = bus.btn_right & ~bus.btn_left;

    always_comb begin
        x_air_d      = x_q + $signed({{5{vx_q[7]}}, vx_q});
        y_air_d      = y_q + $signed({{5{vy_q[7]}}, vy_q});
        vy_grav_d    = (vy_q >= VYMAX_S - GRAV_S) ? VYMAX_S : vy_q + GRAV_S;
        x_left_d     = (x_q < WALK_S) ? 13'sd0 : x_q - WALK_S;
        x_right_d    = (x_q > X_MAX - WALK_S) ? X_MAX : x_q + WALK_S;
        charge_inc_d = charge_q + 5'd1;
        // Holding the button keeps counting; the launch uses the count reached this tick.
        charge_fin_d = bus.btn_jump ? charge_inc_d : charge_q;
        launch_d     = ~bus.btn_jump | (charge_inc_d == CHG_MAX);
        vy_launch_d  = -(JBASE_S + $signed({3'b000, charge_fin_d >> 1}));
        vx_launch_d  = 8'sd0;
        if (left_only) begin
            vx_launch_d = -AIR_S;
        end else if (right_only) begin
            vx_launch_d = AIR_S;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            vblnk_q  <= 1'b0;
            tick_q   <= 1'b0;
            x_q      <= X_INIT;
            y_q      <= GROUND_Y;
            vx_q     <= 8'sd0;
            vy_q     <= 8'sd0;
            charge_q <= 5'd0;
            facing_q <= 1'b0;
            landed_q <= 1'b0;
        end else begin
            vblnk_q  <= bus.vblnk;
            tick_q   <= bus.vblnk & ~vblnk_q;
            landed_q <= 1'b0;
            if (tick_q) begin
                case (state_q)
                    S_IDLE, S_WALK: begin
                        if (bus.btn_jump) begin
                            state_q  <= S_CHARGE;
                            charge_q <= 5'd0;
                        end else if (left_only) begin
                            state_q  <= S_WALK;
                            x_q      <= x_left_d;
                            facing_q <= 1'b1;
                        end else if (right_only) begin
                            state_q  <= S_WALK;
                            x_q      <= x_right_d;
                            facing_q <= 1'b0;
                        end else begin
                            state_q  <= S_IDLE;
                        end
                    end
                    S_CHARGE: begin
                        if (launch_d) begin
                            state_q  <= S_AIR;
                            vy_q     <= vy_launch_d;
                            vx_q     <= vx_launch_d;
                            charge_q <= 5'd0;
                            if (left_only) begin
                                facing_q <= 1'b1;
                            end else if (right_only) begin
                                facing_q <= 1'b0;
                            end
                        end else begin
                            charge_q <= charge_inc_d;
                        end
                    end
                    S_AIR: begin
                        x_q  <= x_air_d;
                        y_q  <= y_air_d;
                        vy_q <= vy_grav_d;
                        if (y_air_d <= 13'sd0) begin
                            y_q  <= 13'sd0;
                            vy_q <= 8'sd0;
                        end
                        if (x_air_d < 13'sd0) begin
                            x_q  <= 13'sd0;
                            vx_q <= -vx_q;
                        end else if (x_air_d > X_MAX) begin
                            x_q  <= X_MAX;
                            vx_q <= -vx_q;
                        end
                        // Touchdown overrides the bounce so the sprite rests with no drift.
                        if (y_air_d >= GROUND_Y) begin
                            y_q      <= GROUND_Y;
                            vy_q     <= 8'sd0;
                            vx_q     <= 8'sd0;
                            landed_q <= 1'b1;
                            state_q  <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.x_value = x_q[11:0];
    assign bus.y_value = y_q[11:0];
    assign bus.pose    = state_q;
    assign bus.facing  = facing_q;
    assign bus.landed  = landed_q;

endmodule

// File: tb/tb_player_ctl.sv
// Scoreboard bench for player_ctl: each frame pushes the expected sprite outputs,
// drives one vblnk tick, then pops and compares once the outputs have updated.
module tb_player_ctl;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [1:0]  pose;
        logic        facing;
        logic        landed;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_run  = 0;
    int   n_fail = 0;
    int   ex, ey, efacing;
    exp_t sb[$];

    player_ctl_if pif();

    player_ctl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (pif)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input int x, input int y, input int p, input int f, input int l);
        return {12'(x), 12'(y), 2'(p), 1'(f), 1'(l)};
    endfunction

    function automatic exp_t obs();
        return {pif.x_value, pif.y_value, pif.pose, pif.facing, pif.landed};
    endfunction

    function automatic string fmt(input exp_t v);
        return $sformatf("x=%0d y=%0d pose=%0d facing=%0d landed=%0d", v.x, v.y, v.pose, v.facing, v.landed);
    endfunction

    // Reference flight step: move, gravity with saturation, ceiling, walls, ground.
    task automatic model_air(inout int x, inout int y, inout int vx, inout int vy, output bit land);
        y = y + vy;
        x = x + vx;
        vy = vy + 1;
        if (vy > 12) vy = 12;
        land = 1'b0;
        if (y <= 0) begin y = 0; vy = 0; end
        if (x < 0) begin x = 0; vx = -vx; end
        else if (x > 752) begin x = 752; vx = -vx; end
        if (y >= 536) begin y = 536; vy = 0; vx = 0; land = 1'b1; end
    endtask

    // One frame: random button noise between ticks, then the real buttons with a vblnk rise.
    task automatic frame(input logic l, input logic r, input logic j);
        @(posedge clk); #1;
        pif.btn_left  = 1'($urandom);
        pif.btn_right = 1'($urandom);
        pif.btn_jump  = 1'($urandom);
        @(posedge clk); #1;
        pif.btn_left  = l;
        pif.btn_right = r;
        pif.btn_jump  = j;
        pif.vblnk     = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        pif.vblnk     = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e, g;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back(mk(376, 536, 0, 0, 0));
        g = obs(); e = sb.pop_front(); n_run++;
        if (g !== e) begin n_fail++; $display("FAIL reset_value: got %s, want %s", fmt(g), fmt(e)); end
        rst_n = 1'b1;
        ex = 376; ey = 536; efacing = 0;
        for (int k = 0; k < 5; k++) begin
            sb.push_back(mk(ex, ey, 0, efacing, 0));
            frame(1'b0, 1'b0, 1'b0);
            g = obs(); e = sb.pop_front(); n_run++;
            if (g !== e) begin n_fail++; $display("FAIL idle_tick[%0d]: got %s, want %s", k, fmt(g), fmt(e)); end
        end
    endtask

    task automatic test_walk_right();
        exp_t e, g;
        for (int k = 0; k < 10; k++) begin
            ex = ex + 2;
            sb.push_back(mk(ex, ey, 1, 0, 0));
            frame(1'b0, 1'b1, 1'b0);
            g = obs(); e = sb.pop_front(); n_run++;
            if (g !== e) begin n_fail++; $display("FAIL walk_right[%0d]: got %s, want %s", k, fmt(g), fmt(e)); end
        end
        n_run++;
        if (pif.x_value !== 12'd396) begin n_fail++; $display("FAIL walk_right_total: got x=%0d, want 396", pif.x_value); end
        // vblnk held high: only the single rising edge may move the sprite.
        @(posedge clk); #1;
        pif.btn_left = 1'b0; pif.btn_right = 1'b1; pif.btn_jump = 1'b0; pif.vblnk = 1'b1;
        ex = ex + 2;
        sb.push_back(mk(ex, ey, 1, 0, 0));
        repeat (8) @(posedge clk);
        #1;
        g = obs(); e = sb.pop_front(); n_run++;
        if (g !== e) begin n_fail++; $display("FAIL vblnk_held: got %s, want %s", fmt(g), fmt(e)); end
        pif.vblnk = 1'b0;
        for (int k = 0; k < 400 && ex < 752; k++) begin
            ex = (ex + 2 > 752) ? 752 : ex + 2;
            sb.push_back(mk(ex, ey, 1, 0, 0));
            frame(1'b0, 1'b1, 1'b0);
            g = obs(); e = sb.pop_front(); n_run++;
            if (g !== e) begin n_fail++; $display("FAIL walk_to_wall[%0d]: got %s, want %s", k, fmt(g), fmt(e)); end
        end
        sb.push_back(mk(752, ey, 1, 0, 0));
        frame(1'b0, 1'b1, 1'b0);
        g = obs(); e = sb.pop_front(); n_run++;
        if (g !== e) begin n_fail++; $display("FAIL right_clamp: got %s, want %s", fmt(g), fmt(e)); end
        sb.push_back(mk(752, ey, 0, 0, 0));
        frame(1'b1, 1'b1, 1'b0);
        g = obs(); e = sb.pop_front(); n_run++;
        if (g !== e) begin n_fail++; $display("FAIL both_buttons_idle: got %s, want %s", fmt(g), fmt(e)); end
        efacing = 0;
    endtask

    task automatic test_jump();
        exp_t e, g;
        int vx, vy;
        bit land;
        for (int k = 0; k < 11; k++) begin
            sb.push_back(mk(ex, ey, 2, efacing, 0));
            frame(1'b0, 1'b0, 1'b1);
            g = obs(); e = sb.pop_front(); n_run++;
            if (g !== e) begin n_fail++; $display("FAIL charge[%0d]: got %s, want %s", k, fmt(g), fmt(e)); end
        end
        sb.push_back(mk(ex, ey, 3, efacing, 0));
        frame(1'b0, 1'b0, 1'b0);
        g = obs(); e = sb.pop_front(); n_run++;
        if (g !== e) begin n_fail++; $display("FAIL launch: got %s, want %s", fmt(g), fmt(e)); end
        vx = 0; vy = -9;
        for (int t = 1; t <= 19; t++) begin
            model_air(ex, ey, vx, vy, land);
            sb.push_back(mk(ex, ey, land ? 0 : 3, efacing, land));
            frame(1'($urandom), 1'($urandom), 1'b0);
            g = obs(); e = sb.pop_front(); n_run++;
            if (g !== e) begin n_fail++; $display("FAIL jump_air[%0d]: got %s, want %s", t, fmt(g), fmt(e)); end
            if (t == 9) begin
                n_run++;
                if (pif.y_value !== 12'd491) begin n_fail++; $display("FAIL jump_apex: got y=%0d, want 491", pif.y_value); end
            end
            if (t == 19) begin
                @(posedge clk); #1;
                n_run++;
                if (pif.landed !== 1'b0) begin n_fail++; $display("FAIL landed_width: got landed=%0d, want 0", pif.landed); end
            end
        end
    endtask

    task automatic test_auto_launch();
        exp_t e, g;
        int vx, vy, t;
        bit land;
        sb.push_back(mk(ex, ey, 2, efacing, 0));
        frame(1'b0, 1'b0, 1'b1);
        g = obs(); e = sb.pop_front(); n_run++;
        if (g !== e) begin n_fail++; $display("FAIL auto_enter: got %s, want %s", fmt(g), fmt(e)); end
        for (int k = 1; k <= 30; k++) begin
            sb.push_back(mk(ex, ey, (k == 30) ? 3 : 2, efacing, 0));
            frame(1'b0, 1'b0, 1'b1);
            g = obs(); e = sb.pop_front(); n_run++;
            if (g !== e) begin n_fail++; $display("FAIL auto_charge[%0d]: got %s, want %s", k, fmt(g), fmt(e)); end
        end
        vx = 0; vy = -19; t = 0; land = 1'b0;
        while (!land && t < 60) begin
            t++;
            model_air(ex, ey, vx, vy, land);
            sb.push_back(mk(ex, ey, land ? 0 : 3, efacing, land));
            frame(1'b0, 1'b0, 1'b1);
            g = obs(); e = sb.pop_front(); n_run++;
            if (g !== e) begin n_fail++; $display("FAIL auto_air[%0d]: got %s, want %s", t, fmt(g), fmt(e)); end
        end
        n_run++;
        if (t !== 42) begin n_fail++; $display("FAIL auto_flight_len: got %0d ticks, want 42", t); end
        sb.push_back(mk(ex, ey, 2, efacing, 0));
        frame(1'b0, 1'b0, 1'b1);
        g = obs(); e = sb.pop_front(); n_run++;
        if (g !== e) begin n_fail++; $display("FAIL recharge_after_land: got %s, want %s", fmt(g), fmt(e)); end
        sb.push_back(mk(ex, ey, 3, efacing, 0));
        frame(1'b0, 1'b0, 1'b0);
        g = obs(); e = sb.pop_front(); n_run++;
        if (g !== e) begin n_fail++; $display("FAIL short_launch: got %s, want %s", fmt(g), fmt(e)); end
        vx = 0; vy = -4; t = 0; land = 1'b0;
        while (!land && t < 20) begin
            t++;
            model_air(ex, ey, vx, vy, land);
            sb.push_back(mk(ex, ey, land ? 0 : 3, efacing, land));
            frame(1'b0, 1'b0, 1'b0);
            g = obs(); e = sb.pop_front(); n_run++;
            if (g !== e) begin n_fail++; $display("FAIL short_air[%0d]: got %s, want %s", t, fmt(g), fmt(e)); end
        end
    endtask

    task automatic test_reset_mid_air();
        exp_t e, g;
        frame(1'b0, 1'b0, 1'b1);
        repeat (10) frame(1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0, 1'b0);
        repeat (5) frame(1'b0, 1'b0, 1'b0);
        n_run++;
        if (pif.y_value !== 12'd501 || pif.pose !== 2'd3) begin
            n_fail++; $display("FAIL pre_reset_air: got y=%0d pose=%0d, want y=501 pose=3", pif.y_value, pif.pose);
        end
        #3 rst_n = 1'b0;
        #1;
        sb.push_back(mk(376, 536, 0, 0, 0));
        g = obs(); e = sb.pop_front(); n_run++;
        if (g !== e) begin n_fail++; $display("FAIL reset_mid_air: got %s, want %s", fmt(g), fmt(e)); end
        @(posedge clk); #1 rst_n = 1'b1;
        ex = 376; ey = 536; efacing = 0;
        sb.push_back(mk(ex, ey, 0, 0, 0));
        frame(1'b0, 1'b0, 1'b0);
        g = obs(); e = sb.pop_front(); n_run++;
        if (g !== e) begin n_fail++; $display("FAIL after_air_reset: got %s, want %s", fmt(g), fmt(e)); end
        sb.push_back(mk(ex, ey, 2, 0, 0));
        frame(1'b0, 1'b0, 1'b1);
        g = obs(); e = sb.pop_front(); n_run++;
        if (g !== e) begin n_fail++; $display("FAIL charge_before_reset: got %s, want %s", fmt(g), fmt(e)); end
        #3 rst_n = 1'b0;
        #1;
        sb.push_back(mk(376, 536, 0, 0, 0));
        g = obs(); e = sb.pop_front(); n_run++;
        if (g !== e) begin n_fail++; $display("FAIL reset_mid_charge: got %s, want %s", fmt(g), fmt(e)); end
        @(posedge clk); #1 rst_n = 1'b1;
        sb.push_back(mk(ex, ey, 0, 0, 0));
        frame(1'b0, 1'b0, 1'b0);
        g = obs(); e = sb.pop_front(); n_run++;
        if (g !== e) begin n_fail++; $display("FAIL no_pending_launch: got %s, want %s", fmt(g), fmt(e)); end
    endtask

    task automatic test_left_bounce();
        exp_t e, g;
        int vx, vy, t;
        bit land;
        int xs[6];
        xs = '{7, 4, 1, 0, 3, 6};
        for (int k = 0; k < 400 && ex > 8; k++) begin
            ex = ex - 2; efacing = 1;
            sb.push_back(mk(ex, ey, 1, 1, 0));
            frame(1'b1, 1'b0, 1'b0);
            g = obs(); e = sb.pop_front(); n_run++;
            if (g !== e) begin n_fail++; $display("FAIL walk_left[%0d]: got %s, want %s", k, fmt(g), fmt(e)); end
        end
        ex = 10; efacing = 0;
        sb.push_back(mk(ex, ey, 1, 0, 0));
        frame(1'b0, 1'b1, 1'b0);
        g = obs(); e = sb.pop_front(); n_run++;
        if (g !== e) begin n_fail++; $display("FAIL face_right: got %s, want %s", fmt(g), fmt(e)); end
        sb.push_back(mk(ex, ey, 2, 0, 0));
        frame(1'b1, 1'b0, 1'b1);
        g = obs(); e = sb.pop_front(); n_run++;
        if (g !== e) begin n_fail++; $display("FAIL jump_priority: got %s, want %s", fmt(g), fmt(e)); end
        efacing = 1;
        sb.push_back(mk(ex, ey, 3, 1, 0));
        frame(1'b1, 1'b0, 1'b0);
        g = obs(); e = sb.pop_front(); n_run++;
        if (g !== e) begin n_fail++; $display("FAIL left_launch: got %s, want %s", fmt(g), fmt(e)); end
        vx = -3; vy = -4; t = 0; land = 1'b0;
        while (!land && t < 20) begin
            t++;
            model_air(ex, ey, vx, vy, land);
            sb.push_back(mk(ex, ey, land ? 0 : 3, efacing, land));
            frame(1'b0, 1'($urandom), 1'b0);
            g = obs(); e = sb.pop_front(); n_run++;
            if (g !== e) begin n_fail++; $display("FAIL bounce_air[%0d]: got %s, want %s", t, fmt(g), fmt(e)); end
            if (t <= 6) begin
                n_run++;
                if (pif.x_value !== 12'(xs[t-1])) begin
                    n_fail++; $display("FAIL bounce_x[%0d]: got x=%0d, want %0d", t, pif.x_value, xs[t-1]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pif.vblnk = 1'b0;
        pif.btn_left = 1'b0;
        pif.btn_right = 1'b0;
        pif.btn_jump = 1'b0;
        test_reset();
        test_walk_right();
        test_jump();
        test_auto_launch();
        test_reset_mid_air();
        test_left_bounce();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
